serial_word_loader: RTL

Upstream feeder for the N-bit load-enabled holding register. It assembles an MSB-first serial bit stream into an N-bit word. When a frame completes, it presents the word on `word` with a one-cycle `load` strobe, which wires directly to the register's `d` and `ena`. Frames are delimited by a start-of-frame flag, and bits may arrive with arbitrary gaps.

---
 rtl/serial_word_loader_if.sv | 23 ++
 rtl/serial_word_loader.sv | 115 +++++++++++
 2 files changed

// File: rtl/serial_word_loader_if.sv
// Serial bit-stream and completed-word bundle for serial_word_loader.
// The master drives the serial side; the slave (the loader) drives word/strobes.
interface serial_word_loader_if #(
    parameter int unsigned N = 8
);
    logic         sin;
    logic         bit_valid;
    logic         sof;
    logic [N-1:0] word;
    logic         load;
    logic         busy;
    logic         parity_err;

    modport master (
        output sin, bit_valid, sof,
        input  word, load, busy, parity_err
    );

    modport slave (
        input  sin, bit_valid, sof,
        output word, load, busy, parity_err
    );
endinterface

// File: rtl/serial_word_loader.sv
// MSB-first serial-to-parallel word assembler with sof resync and a one-cycle load strobe.
// Define SERIAL_LOADER_PARITY_EN to append an even-parity bit to every frame.
module serial_word_loader #(
    parameter int unsigned N = 8
) (
    input logic                clk,
    input logic                rst,
    serial_word_loader_if.slave bus
);
    localparam int unsigned CW = $clog2(N + 1);

`ifdef SERIAL_LOADER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;
`else
    typedef enum logic [1:0] {StIdle, StData} state_e;
`endif

    state_e          state_q, state_d;
    logic [N-1:0]    sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    word_q, word_d;
    logic            load_q, load_d;
`ifdef SERIAL_LOADER_PARITY_EN
    logic            perr_q, perr_d;
`endif
    logic [N-1:0]    shifted;

    assign shifted = {sr_q[N-2:0], bus.sin};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            word_q <= '0;
            load_q <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
            load_q <= load_d;
`ifdef SERIAL_LOADER_PARITY_EN
            perr_q <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        load_d  = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (bus.bit_valid) begin
            if (bus.sof) begin
                // sof always starts a fresh frame, discarding any partial one
                sr_d    = shifted;
                cnt_d   = CW'(1);
                state_d = StData;
            end else begin
                case (state_q)
                    StData: begin
                        sr_d  = shifted;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) begin
`ifdef SERIAL_LOADER_PARITY_EN
                            state_d = StParity;
`else
                            word_d  = shifted;
                            load_d  = 1'b1;
                            state_d = StIdle;
`endif
                        end
                    end
`ifdef SERIAL_LOADER_PARITY_EN
                    StParity: begin
                        if (bus.sin == ^sr_q) begin
                            word_d = sr_q;
                            load_d = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
                        state_d = StIdle;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.busy = (state_q != StIdle);
        bus.word = word_q;
        bus.load = load_q;
`ifdef SERIAL_LOADER_PARITY_EN
        bus.parity_err = perr_q;
`else
        bus.parity_err = 1'b0;
`endif
    end
endmodule
